// File: rtl/decoder_arb_pkg.sv
// Shared types and the rotating-priority pick function for the round-robin
// arbiter that drives a one-hot decoded select.
package decoder_arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // First set request scanning from ptr upward, indices wrapping mod N_REQ.
  function automatic pick_t rr_pick(input logic [N_REQ-1:0] req,
                                    input logic [IDX_W-1:0] ptr);
    pick_t            res;
    logic [IDX_W-1:0] cand;
    res.found = 1'b0;
    res.idx   = {IDX_W{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      cand = ptr + IDX_W'(i);
      if (!res.found && req[cand]) begin
        res.found = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/onehot_dec3to8.sv
// 3-to-8 one-hot decoder with enable; output is all zeros when disabled.
module onehot_dec3to8 (
  input  logic [2:0] din,
  input  logic       en,
  output logic [7:0] dout
);

  assign dout = en ? (8'h01 << din) : 8'h00;

endmodule

// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter for 8 requesters: registered grant index, one dead
// cycle between owners, and a bounded hold time with a timeout pulse.
module decoder_rr_arbiter
  import decoder_arb_pkg::*;
#(
  parameter int HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam int HCNT_W = $clog2(HOLD_MAX + 1);

  arb_state_t       state_r, state_s;
  logic [IDX_W-1:0] ptr_r, ptr_s;
  logic [HCNT_W-1:0] hcnt_r, hcnt_s;
  logic [IDX_W-1:0] gnt_idx_r, gnt_idx_s;
  logic             gnt_valid_r, gnt_valid_s;
  logic             timeout_r, timeout_s;
  pick_t            pick_s;
  logic             hold_hit_s;
  logic             withdraw_s;

  // Next-state, pointer, hold counter and output-register inputs.
  always_comb begin
    state_s     = state_r;
    ptr_s       = ptr_r;
    hcnt_s      = hcnt_r;
    gnt_idx_s   = gnt_idx_r;
    gnt_valid_s = gnt_valid_r;
    timeout_s   = 1'b0;
    pick_s      = rr_pick(req, ptr_r);
    hold_hit_s  = (hcnt_r == HCNT_W'(HOLD_MAX - 1));
    withdraw_s  = ~req[gnt_idx_r];

    case (state_r)
      IDLE, GAP: begin
        if (pick_s.found) begin
          state_s     = GRANT;
          gnt_idx_s   = pick_s.idx;
          gnt_valid_s = 1'b1;
          hcnt_s      = {HCNT_W{1'b0}};
        end else begin
          state_s     = IDLE;
          gnt_valid_s = 1'b0;
        end
      end
      GRANT: begin
        if (done || withdraw_s || hold_hit_s) begin
          state_s     = GAP;
          gnt_valid_s = 1'b0;
          ptr_s       = gnt_idx_r + 3'd1;
          // Only a pure hold-limit release is reported as a timeout.
          timeout_s   = hold_hit_s & ~done & ~withdraw_s;
        end else begin
          hcnt_s = hcnt_r + HCNT_W'(1);
        end
      end
      default: begin
        state_s     = IDLE;
        gnt_valid_s = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      ptr_r       <= {IDX_W{1'b0}};
      hcnt_r      <= {HCNT_W{1'b0}};
      gnt_idx_r   <= {IDX_W{1'b0}};
      gnt_valid_r <= 1'b0;
      timeout_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      ptr_r       <= ptr_s;
      hcnt_r      <= hcnt_s;
      gnt_idx_r   <= gnt_idx_s;
      gnt_valid_r <= gnt_valid_s;
      timeout_r   <= timeout_s;
    end
  end

  onehot_dec3to8 u_dec (
    .din  (gnt_idx_r),
    .en   (gnt_valid_r),
    .dout (gnt)
  );

  assign gnt_idx   = gnt_idx_r;
  assign gnt_valid = gnt_valid_r;
  assign timeout   = timeout_r;

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Directed scoreboard bench for decoder_rr_arbiter with a hold limit of 4.
module tb_decoder_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  typedef struct {
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       valid;
    logic       to;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  decoder_rr_arbiter #(.HOLD_MAX(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic expect_out(input logic [2:0] idx, input logic valid, input logic to);
    exp_t e;
    e.idx   = idx;
    e.valid = valid;
    e.to    = to;
    e.gnt   = valid ? (8'h01 << idx) : 8'h00;
    sb.push_back(e);
  endtask

  task automatic compare(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      checks++;
      assert (gnt === e.gnt) else begin
        errors++;
        $error("FAIL %s gnt: got %h expected %h", tag, gnt, e.gnt);
      end
      checks++;
      assert (gnt_valid === e.valid) else begin
        errors++;
        $error("FAIL %s gnt_valid: got %b expected %b", tag, gnt_valid, e.valid);
      end
      checks++;
      assert (gnt_idx === e.idx) else begin
        errors++;
        $error("FAIL %s gnt_idx: got %0d expected %0d", tag, gnt_idx, e.idx);
      end
      checks++;
      assert (timeout === e.to) else begin
        errors++;
        $error("FAIL %s timeout: got %b expected %b", tag, timeout, e.to);
      end
    end
  endtask

  // Drive one cycle of inputs, record the expected post-edge outputs, check them.
  task automatic cyc(input logic [7:0] r, input logic d, input logic [2:0] idx,
                     input logic valid, input logic to, input string tag);
    req  = r;
    done = d;
    expect_out(idx, valid, to);
    @(posedge clk);
    #1;
    compare(tag);
  endtask

  initial begin
    logic [2:0] kk;
    rst_n = 1'b0;
    req   = 8'hFF;
    done  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expect_out(3'd0, 1'b0, 1'b0);
    compare("reset");
    rst_n = 1'b1;
    cyc(8'hFF, 1'b0, 3'd0, 1'b1, 1'b0, "first_grant");

    // Fairness: full request vector, one-cycle grants.
    for (int k = 0; k < 8; k++) begin
      kk = 3'(k);
      cyc(8'hFF, 1'b1, kk, 1'b0, 1'b0, $sformatf("fair_gap%0d", k));
      cyc(8'hFF, 1'b0, kk + 3'd1, 1'b1, 1'b0, $sformatf("fair_grant%0d", k));
    end

    // Single requester, then pointer check.
    cyc(8'h04, 1'b1, 3'd0, 1'b0, 1'b0, "rel0");
    cyc(8'h04, 1'b0, 3'd2, 1'b1, 1'b0, "single_grant");
    cyc(8'h04, 1'b1, 3'd2, 1'b0, 1'b0, "single_gap");
    cyc(8'h00, 1'b0, 3'd2, 1'b0, 1'b0, "single_idle");
    cyc(8'h0C, 1'b0, 3'd3, 1'b1, 1'b0, "ptr3");

    // Wrap from pointer 6 to lower indices.
    cyc(8'h20, 1'b1, 3'd3, 1'b0, 1'b0, "gap3");
    cyc(8'h20, 1'b0, 3'd5, 1'b1, 1'b0, "grant5");
    cyc(8'h20, 1'b1, 3'd5, 1'b0, 1'b0, "gap5");
    cyc(8'h03, 1'b0, 3'd0, 1'b1, 1'b0, "wrap_grant0");
    cyc(8'h03, 1'b1, 3'd0, 1'b0, 1'b0, "wrap_gap0");
    cyc(8'h03, 1'b0, 3'd1, 1'b1, 1'b0, "wrap_grant1");
    cyc(8'h00, 1'b0, 3'd1, 1'b0, 1'b0, "withdraw1");
    cyc(8'h00, 1'b0, 3'd1, 1'b0, 1'b0, "idle1");

    // Hold limit: four grant cycles, then a timeout gap.
    cyc(8'h10, 1'b0, 3'd4, 1'b1, 1'b0, "hold_c1");
    cyc(8'h10, 1'b0, 3'd4, 1'b1, 1'b0, "hold_c2");
    cyc(8'h10, 1'b0, 3'd4, 1'b1, 1'b0, "hold_c3");
    cyc(8'h10, 1'b0, 3'd4, 1'b1, 1'b0, "hold_c4");
    cyc(8'h10, 1'b0, 3'd4, 1'b0, 1'b1, "timeout_gap");
    cyc(8'h10, 1'b0, 3'd4, 1'b1, 1'b0, "regrant_c1");
    cyc(8'h10, 1'b0, 3'd4, 1'b1, 1'b0, "regrant_c2");
    cyc(8'h10, 1'b0, 3'd4, 1'b1, 1'b0, "regrant_c3");
    cyc(8'h10, 1'b0, 3'd4, 1'b1, 1'b0, "regrant_c4");
    cyc(8'h10, 1'b1, 3'd4, 1'b0, 1'b0, "done_at_limit");
    cyc(8'h00, 1'b0, 3'd4, 1'b0, 1'b0, "idle4");

    // Asynchronous reset in the middle of a grant.
    cyc(8'h08, 1'b0, 3'd3, 1'b1, 1'b0, "grant3");
    #2;
    rst_n = 1'b0;
    #1;
    expect_out(3'd0, 1'b0, 1'b0);
    compare("async_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(8'h80, 1'b0, 3'd7, 1'b1, 1'b0, "grant7");
    cyc(8'h00, 1'b0, 3'd7, 1'b0, 1'b0, "withdraw7");

    // Withdrawal coinciding with the hold limit gives no timeout.
    cyc(8'h80, 1'b0, 3'd7, 1'b1, 1'b0, "lim_c1");
    cyc(8'h80, 1'b0, 3'd7, 1'b1, 1'b0, "lim_c2");
    cyc(8'h80, 1'b0, 3'd7, 1'b1, 1'b0, "lim_c3");
    cyc(8'h80, 1'b0, 3'd7, 1'b1, 1'b0, "lim_c4");
    cyc(8'h00, 1'b0, 3'd7, 1'b0, 1'b0, "withdraw_at_limit");
    cyc(8'h00, 1'b0, 3'd7, 1'b0, 1'b0, "idle7");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
